// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: FSM states and the
// select codes forwarded unchanged to the ALU's s input.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1111;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_ZERO = 4'b0000;

    localparam int unsigned SETTLE_W = 4;

    // Value loaded into the settle counter when the ALU is triggered.
    function automatic logic [SETTLE_W-1:0] settle_load(input int unsigned settle_cycles);
        return SETTLE_W'(settle_cycles - 1);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Single-op-in-flight sequencer in front of the toggle-triggered 64-bit ALU:
// latches a request, toggles en, waits a fixed settle time, returns the result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [WIDTH-1:0] rsp_mulh,
    output logic [7:0]       rsp_flag,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [3:0]       alu_s,
    output logic             alu_en,
    output logic [WIDTH-1:0] alu_inp1,
    output logic [WIDTH-1:0] alu_inp2,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] alu_mulh,
    input  logic [7:0]       alu_flag
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    logic             req_ready_d, busy_d, rsp_valid_d, alu_en_d;
    logic [3:0]       alu_s_d;
    logic [WIDTH-1:0] alu_inp1_d, alu_inp2_d;
    logic [WIDTH-1:0] rsp_out_d, rsp_mulh_d;
    logic [7:0]       rsp_flag_d;
    logic [CNT_W-1:0] op_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_en_d    = alu_en;
        alu_s_d     = alu_s;
        alu_inp1_d  = alu_inp1;
        alu_inp2_d  = alu_inp2;
        rsp_valid_d = rsp_valid;
        rsp_out_d   = rsp_out;
        rsp_mulh_d  = rsp_mulh;
        rsp_flag_d  = rsp_flag;
        op_count_d  = op_count;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    alu_s_d    = req_op;
                    alu_inp1_d = req_a;
                    alu_inp2_d = req_b;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Operands have been stable for a full cycle; the toggle starts the ALU.
                alu_en_d = ~alu_en;
                cnt_d    = SETTLE_LOAD;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_out_d   = alu_out;
                    rsp_mulh_d  = alu_mulh;
                    rsp_flag_d  = alu_flag;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the upcoming state.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            alu_en    <= 1'b0;
            alu_s     <= '0;
            alu_inp1  <= '0;
            alu_inp2  <= '0;
            rsp_out   <= '0;
            rsp_mulh  <= '0;
            rsp_flag  <= '0;
            op_count  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            alu_en    <= alu_en_d;
            alu_s     <= alu_s_d;
            alu_inp1  <= alu_inp1_d;
            alu_inp2  <= alu_inp2_d;
            rsp_out   <= rsp_out_d;
            rsp_mulh  <= rsp_mulh_d;
            rsp_flag  <= rsp_flag_d;
            op_count  <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural toggle-triggered ALU
// attached to its alu_* ports.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a, req_b;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_out, rsp_mulh;
    logic [7:0]       rsp_flag;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic [3:0]       alu_s;
    logic             alu_en;
    logic [WIDTH-1:0] alu_inp1, alu_inp2, alu_out, alu_mulh;
    logic [7:0]       alu_flag;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_mulh(rsp_mulh), .rsp_flag(rsp_flag),
        .busy(busy), .op_count(op_count),
        .alu_s(alu_s), .alu_en(alu_en), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
        .alu_out(alu_out), .alu_mulh(alu_mulh), .alu_flag(alu_flag)
    );

    typedef struct packed {
        logic [63:0] out;
        logic [63:0] mulh;
        logic [7:0]  flag;
    } res_t;

    typedef struct {
        res_t        r;
        int unsigned acc;
        int unsigned tog;
    } exp_t;

    // ALU behaviour: flag[7]=sign, flag[6]=zero, flag[2]=carry/borrow, flag[0]=parity.
    function automatic res_t alu_model(input logic [3:0] s, input logic [63:0] a, input logic [63:0] b);
        res_t         r;
        logic [64:0]  sum;
        logic [127:0] prod;
        r = '0;
        case (s)
            OP_ADD: begin sum = {1'b0, a} + {1'b0, b}; r.out = sum[63:0]; r.flag[2] = sum[64]; end
            OP_SUB: begin r.out = a - b; r.flag[2] = (a < b); end
            OP_MUL: begin prod = {64'b0, a} * {64'b0, b}; r.out = prod[63:0]; r.mulh = prod[63:0]; end
            OP_CMP: r.out = {61'b0, (a < b), (a == b), (a > b)};
            OP_AND: r.out = a & b;
            default: r.out = '0;
        endcase
        r.flag[6] = (r.out == 64'd0);
        r.flag[7] = r.out[63];
        r.flag[0] = ^r.out;
        return r;
    endfunction

    res_t alu_res = '0;
    always @(alu_en) alu_res = alu_model(alu_s, alu_inp1, alu_inp2);
    assign alu_out  = alu_res.out;
    assign alu_mulh = alu_res.mulh;
    assign alu_flag = alu_res.flag;

    int unsigned n_chk = 0, n_fail = 0;
    int unsigned cyc = 0, tog = 0, last_acc = 0, n_iss = 0;
    exp_t        q[$];
    bit          rand_rdy = 1'b0;
    logic        prev_v = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always @(posedge clk) cyc++;
    always @(alu_en) if (rst_n === 1'b1) tog++;
    always @(negedge clk) if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: samples just after the falling edge, when all inputs are settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                q.delete();
                exp_cnt = '0;
                prev_v  = 1'b0;
            end else begin
                chk("op_count", 64'(op_count), 64'(exp_cnt));
                if (rsp_valid) begin
                    chk("req_ready_in_resp", 64'(req_ready), 64'd0);
                    chk("busy_in_resp", 64'(busy), 64'd1);
                    if (q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (cycle %0d)", cyc);
                    end else begin
                        e = q[0];
                        chk("rsp_out", rsp_out, e.r.out);
                        chk("rsp_mulh", rsp_mulh, e.r.mulh);
                        chk("rsp_flag", 64'(rsp_flag), 64'(e.r.flag));
                        if (!prev_v) begin
                            chk("latency", 64'(cyc - e.acc), 64'(SETTLE + 1));
                            chk("en_toggles", 64'(tog - e.tog), 64'd1);
                        end
                        if (rsp_ready) begin
                            void'(q.pop_front());
                            exp_cnt++;
                        end
                    end
                end
                prev_v = rsp_valid;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit chk_period);
        int unsigned w = 0;
        while (!req_ready && w < 200) begin @(negedge clk); w++; end
        if (!req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL req_ready_timeout: got req_ready=0 for %0d cycles, expected 1", w);
            return;
        end
        if (chk_period) chk("issue_period", 64'(cyc - last_acc), 64'(SETTLE + 2));
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        q.push_back('{r: alu_model(op, a, b), acc: cyc + 1, tog: tog});
        last_acc = cyc + 1;
        n_iss++;
        @(negedge clk);
        req_valid = 1'b0; req_op = 4'($urandom); req_a = rand64(); req_b = rand64();
        chk("alu_s", 64'(alu_s), 64'(op));
        chk("alu_inp1", alu_inp1, a);
        chk("alu_inp2", alu_inp2, b);
    endtask

    task automatic wait_drain();
        int unsigned w = 0;
        while ((q.size() != 0 || !req_ready) && w < 300) begin @(negedge clk); w++; end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_alu_en"}, 64'(alu_en), 64'd0);
        chk({tag, "_alu_s"}, 64'(alu_s), 64'd0);
        chk({tag, "_alu_inp1"}, alu_inp1, 64'd0);
        chk({tag, "_alu_inp2"}, alu_inp2, 64'd0);
        chk({tag, "_rsp_out"}, rsp_out, 64'd0);
        chk({tag, "_rsp_mulh"}, rsp_mulh, 64'd0);
        chk({tag, "_rsp_flag"}, 64'(rsp_flag), 64'd0);
        chk({tag, "_op_count"}, 64'(op_count), 64'd0);
    endtask

    initial begin
        logic [3:0] ops [6];
        int unsigned w;
        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_AND, OP_ZERO};
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_req_ready", 64'(req_ready), 64'd1);
            chk("idle_alu_en", 64'(alu_en), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end

        rsp_ready = 1'b1;
        issue(OP_ADD, 64'd5, 64'd7, 1'b0);
        issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_drain();

        // Response held off: values must stay put and new requests are ignored.
        rsp_ready = 1'b0;
        issue(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
        w = 0;
        while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
        chk("mul_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (5) begin
            req_valid = 1'b1; req_op = OP_AND; req_a = rand64(); req_b = rand64();
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold_alu_s_kept", 64'(alu_s), 64'(OP_MUL));
        chk("hold_alu_inp1_kept", alu_inp1, 64'h1_0000_0000);
        chk("hold_alu_en_quiet", 64'(tog), 64'(n_iss));

        issue(OP_CMP, 64'd3, 64'd9, 1'b0);
        issue(OP_ADD, rand64(), rand64(), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_iss = 0; tog = 0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end

        rand_rdy = 1'b1;
        repeat (40) issue(ops[$urandom_range(0, 5)], rand64(), rand64(), 1'b0);
        rand_rdy = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        wait_drain();

        issue(OP_ZERO, rand64(), rand64(), 1'b0);
        repeat (259) issue(OP_ZERO, rand64(), rand64(), 1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("op_count_wrapped", 64'(op_count), 64'(n_iss % (1 << CNT_W)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected completion within 2ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing front-end that sits directly upstream of the 64-bit ALU (bit64alu).
- Accepts operation requests on a valid/ready handshake, registers the opcode and operands, and drives the ALU select/operand inputs.
- Toggles the ALU's en input once per operation, waits a fixed settle time, captures out/mulh/flag, and returns them on a response valid/ready handshake.
- Exactly one operation is in flight at a time.

Parameters:
- WIDTH, 64: operand/result width; must match the ALU datapath.
- SETTLE_CYCLES, 2: clock cycles between the en toggle and result capture; legal range 1..15.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  4  ALU select code, forwarded unchanged to alu_s
- req_a  in  WIDTH  operand 1
- req_b  in  WIDTH  operand 2
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_out  out  WIDTH  captured ALU out
- rsp_mulh  out  WIDTH  captured ALU mulh
- rsp_flag  out  8  captured ALU flag
- busy  out  1  high in any state other than IDLE
- op_count  out  CNT_W  number of completed responses
- alu_s  out  4  to ALU s
- alu_en  out  1  to ALU en (toggle-triggered)
- alu_inp1  out  WIDTH  to ALU inp1
- alu_inp2  out  WIDTH  to ALU inp2
- alu_out  in  WIDTH  from ALU out
- alu_mulh  in  WIDTH  from ALU mulh
- alu_flag  in  8  from ALU flag

Behaviour:
- Reset (async assert, sync release): state=IDLE; all of req_ready, rsp_valid, busy, alu_en, alu_s, alu_inp1, alu_inp2, rsp_out, rsp_mulh, rsp_flag, op_count = 0. req_ready rises on the first clock edge after reset release.
- Every output is registered; alu_* are driven only from registers.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_op/req_a/req_b into alu_s/alu_inp1/alu_inp2, then go to ISSUE.
  - ISSUE: one cycle. Invert alu_en. This is the ALU evaluation trigger, so operands are stable for a full cycle before the toggle takes effect. Load the settle counter with SETTLE_CYCLES-1, then go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, capture alu_out/alu_mulh/alu_flag into rsp_*, set rsp_valid=1, and go to RESP.
  - RESP: hold all rsp_* values stable while rsp_valid=1. On rsp_valid&&rsp_ready, clear rsp_valid, increment op_count, and go to IDLE.
- req_ready=0 in ISSUE, WAIT and RESP. There is no back-to-back overlap.
- Minimum cycles per op, accept edge to rsp_valid: 1 (ISSUE) + SETTLE_CYCLES. With the default, rsp_valid is high on the 3rd edge after the accept edge.
- alu_s/alu_inp1/alu_inp2 hold their values after completion until the next accept. alu_en does not toggle again until the next ISSUE.
- Opcodes are not decoded or checked. For codes where the ALU does not update out (e.g. 4'b1101), whatever the ALU presents is captured.
- op_count wraps from all-ones to 0 silently.
- req_valid deasserted in IDLE: no state change. Request fields are don't-care unless req_valid=1.
- rsp_ready held high before rsp_valid: no effect until RESP.
- Reset mid-operation (any state): return immediately to the reset values. alu_en returns to 0, which is itself a toggle; the ALU may therefore re-evaluate with zeroed operands, and this is acceptable. No response is produced for an aborted op.

Decomposition:
- Shared package alu_pkg:
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - named opcode constants as forwarded on s: OP_ADD=4'b1001, OP_SUB=4'b0101, OP_MUL=4'b0111, OP_CMP=4'b1111, OP_AND=4'b0100, OP_ZERO=4'b0000.
- A single module; no sub-module needed. The settle counter is a 4-bit down-counter inline.

Test Plan (bench instantiates alu_issue_ctrl driving a real bit64alu):
- Reset release, idle 3 cycles: all outputs 0, req_ready=1 from the first edge, alu_en stays 0.
- OP_ADD, a=5, b=7, rsp_ready=1: rsp_valid on the 3rd edge after accept; rsp_out=12; alu_en toggled exactly once; op_count=1 after the handshake.
- OP_ADD, a=64'hFFFF_FFFF_FFFF_FFFF, b=1: rsp_out=0, rsp_flag[2]=1, rsp_flag[6]=1.
- OP_MUL, a=64'h1_0000_0000, b=64'h1_0000_0000: rsp_out=0; rsp_mulh equals the ALU mulh output (the ALU assigns the low 64 bits of its 128-bit product to mulh, so rsp_mulh=0). Then hold rsp_ready=0 for 5 cycles: rsp_valid and the values stay stable, req_ready=0, a concurrent req_valid is ignored.
- OP_CMP, a=3, b=9: rsp_out=64'h4. Then assert rst_n low during WAIT of a following op: all outputs reset asynchronously, no rsp_valid, op_count=0.
- 65 536 back-to-back OP_ZERO ops with rsp_ready=1: op_count wraps to 0; each op takes exactly SETTLE_CYCLES+2 cycles from accept to the next req_ready.
